rgb_channel_serializer: RTL

RGB_CHANNEL_SERIALIZER -- requirements
Module: rgb_channel_serializer

---
 rtl/rgb_pkg.sv | 34 +++
 rtl/rgb_channel_serializer_if.sv | 31 +++
 rtl/rgb_pixel_fifo.sv | 56 +++++
 rtl/rgb_channel_serializer.sv | 63 ++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared RGB definitions: pixel field offsets and the channel index encoding
// used by the serializer and the mask stage bench.
package rgb_pkg;

  localparam int R_MSB = 23;
  localparam int G_MSB = 15;
  localparam int B_MSB = 7;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;

  localparam int PIX_W   = 24;
  localparam int ENTRY_W = PIX_W + 1;

  // order=0 sends R,G,B; order=1 sends B,G,R. Green is always the middle byte.
  function automatic logic [7:0] channel_byte(input logic [PIX_W-1:0] pix,
                                              input logic             order,
                                              input logic [1:0]       ch);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = pix[R_MSB -: 8];
    g = pix[G_MSB -: 8];
    b = pix[B_MSB -: 8];
    case (ch)
      CH0:     channel_byte = order ? b : r;
      CH1:     channel_byte = g;
      CH2:     channel_byte = order ? r : b;
      default: channel_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rgb_channel_serializer_if.sv
// Pixel-in / byte-out bus of the RGB channel serializer, plus a debug view of the channel index.
interface rgb_channel_serializer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Both sides use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both 1; valid never waits on ready, and the payload
  // is held stable while valid=1 and ready=0.
  logic          PixValid;
  logic [23:0]   RGBin;
  logic          Order;
  logic          PixReady;
  logic [7:0]    ByteOut;
  logic          ByteValid;
  logic          ByteReady;
  logic          ByteLast;
  logic [CW-1:0] Count;
  logic [1:0]    ChIndex;

  modport master (
    output PixValid, RGBin, Order, ByteReady,
    input  PixReady, ByteOut, ByteValid, ByteLast, Count, ChIndex
  );

  modport slave (
    input  PixValid, RGBin, Order, ByteReady,
    output PixReady, ByteOut, ByteValid, ByteLast, Count, ChIndex
  );

endinterface

// File: rtl/rgb_pixel_fifo.sv
// Circular pixel FIFO with registered occupancy count; storage is never reset,
// so only the pointers and the count define what is visible.
module rgb_pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push && (count != CW'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rgb_channel_serializer.sv
// Queues 24-bit pixels with their channel order and emits them as three bytes
// each, one byte per accepted handshake.
module rgb_channel_serializer
  import rgb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                     CLK,
  input logic                     RST,
  rgb_channel_serializer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0] head;
  logic [CW-1:0]      count;
  logic [1:0]         ch;
  logic               pix_ready;
  logic               byte_valid;
  logic               push;
  logic               fire;
  logic               pop;

  // Ready comes only from occupancy, so a full FIFO never passes a pixel through.
  assign pix_ready  = (count != CW'(DEPTH));
  assign byte_valid = (count != '0);
  assign push       = bus.PixValid && pix_ready;
  assign fire       = byte_valid && bus.ByteReady;
  assign pop        = fire && (ch == CH2);

  rgb_pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data ({bus.Order, bus.RGBin}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ch <= CH0;
    end else if (fire) begin
      case (ch)
        CH0:     ch <= CH1;
        CH1:     ch <= CH2;
        default: ch <= CH0;
      endcase
    end
  end

  assign bus.PixReady  = pix_ready;
  assign bus.ByteValid = byte_valid;
  assign bus.ByteOut   = byte_valid ? channel_byte(head[PIX_W-1:0], head[PIX_W], ch) : 8'h00;
  assign bus.ByteLast  = byte_valid && (ch == CH2);
  assign bus.Count     = count;
  assign bus.ChIndex   = ch;

endmodule
